wb_bttns_debounce: RTL and testbench
====================================

WB_BTTNS_DEBOUNCE -- requirements
Module: wb_bttns_debounce

Interface
REQ-001 Parameter NUM_BTTNS, default 5, number of push-button inputs (1..32).
REQ-002 Parameter CNT_W, default 20, width of the debounce counters and the DBCNT register.
REQ-003 Parameter DB_RESET, default 20'd100000, reset value of DBCNT (about 2 ms at 50 MHz).
REQ-004 Port wb_clk_i, input, 1, the single clock for all logic.
REQ-005 Port wb_rst_n_i, input, 1, reset; asynchronous and active-low.
REQ-006 Port wb_adr_i, input, 32; only bits [5:2] are decoded (64-byte window).
REQ-007 Port wb_dat_i, input, 32, write data.
REQ-008 Port wb_sel_i, input, 4, byte-lane enables.
REQ-009 Port wb_we_i, input, 1, write strobe qualifier.
REQ-010 Port wb_cyc_i, input, 1, Wishbone cycle.
REQ-011 Port wb_stb_i, input, 1, Wishbone strobe.
REQ-012 Port wb_cti_i, input, 3, ignored; every access is treated as classic.
REQ-013 Port wb_bte_i, input, 2, ignored.
REQ-014 Port wb_dat_o, output, 32, read data.
REQ-015 Port wb_ack_o, output, 1, transfer acknowledge.
REQ-016 Port wb_err_o, output, 1, tied 0.
REQ-017 Port wb_rty_o, output, 1, tied 0.
REQ-018 Port bttns_i, input, NUM_BTTNS, raw asynchronous button levels, active-high.
REQ-019 Port irq_o, output, 1, level interrupt.

Function
REQ-020 Each bttns_i bit SHALL pass through a two-flop synchronizer; "sync" below means the second flop.
REQ-021 Each button SHALL have a CNT_W-bit counter, cleared whenever sync equals the debounced state, else incremented.
REQ-022 The debounced state SHALL take the sync value, and the counter SHALL clear, in the cycle the incremented count is >= max(DBCNT,1).
   - Raw-edge-to-DATA latency is therefore 2 synchronizer cycles + max(DBCNT,1) cycles.
REQ-023 A glitch shorter than the threshold SHALL leave the debounced state unchanged and clear the counter.
REQ-024 A DBCNT write SHALL take effect the next cycle; counters already >= the new value SHALL commit on that cycle.
REQ-025 Register map, selected by wb_adr_i[5:2]:
   - 0x0 DATA, RO: debounced state.
   - 0x4 RISE, W1C: bit i sets on a debounced 0->1 of button i.
   - 0x8 IE, RW: interrupt enable per button.
   - 0xC DBCNT, RW: CNT_W bits.
   - All other offsets read 0; writes to them are ignored and acknowledged normally.
REQ-026 Register bits above NUM_BTTNS (and above CNT_W for DBCNT) SHALL read 0 and ignore writes.
REQ-027 Writes SHALL honour wb_sel_i per byte lane; a W1C byte lane with its sel bit low SHALL clear nothing.
REQ-028 If a RISE set event and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-029 wb_ack_o SHALL assert for exactly one cycle, in the cycle after wb_cyc_i & wb_stb_i & !wb_ack_o, so back-to-back strobes ack every other cycle.
REQ-030 The write SHALL commit in the same edge that raises wb_ack_o.
REQ-031 wb_dat_o SHALL be registered with wb_ack_o, SHALL show the register value sampled at the request cycle, and SHALL be 0 when wb_ack_o is low.
REQ-032 Dropping wb_cyc_i or wb_stb_i before ack SHALL abort the access with no side effects; an ack already scheduled still pulses, with wb_dat_o forced to 0 and no write.
REQ-033 irq_o SHALL be registered: irq_o(t+1) = |(RISE & IE)(t).
REQ-034 Falling debounced edges SHALL change DATA only, never RISE.

Reset
REQ-035 While wb_rst_n_i is low, all flops SHALL clear asynchronously:
   - wb_ack_o=0, wb_dat_o=0, irq_o=0.
   - DATA=0, RISE=0, IE=0, synchronizers=0, counters=0.
   - DBCNT=DB_RESET.
REQ-036 Reset asserted mid-transfer SHALL drop wb_ack_o immediately; the pending write SHALL NOT commit.
REQ-037 Deassertion SHALL be synchronized externally; the block SHALL register no button edge caused by reset release when bttns_i=0.

Verification
REQ-038 DBCNT=4; bttns_i[0] 0->1 held -> DATA[0]=1 exactly 6 cycles after the edge; RISE=0x01; irq_o stays 0 with IE=0.
REQ-039 DBCNT=4; 3-cycle pulse on bttns_i[2] -> DATA and RISE remain 0; a later 5-cycle pulse sets RISE[2].
REQ-040 IE=0x03, RISE=0x03 -> irq_o=1; write 0x01 to RISE with sel=0x1 -> RISE=0x02, irq_o stays 1; write 0x02 -> irq_o=0 one cycle later.
REQ-041 W1C of RISE[1] in the same cycle button 1 commits a new rise -> RISE[1] reads 1.
REQ-042 Continuous cyc/stb reads of 0xC after reset -> ack on alternate cycles, data 0x000186A0; a read of offset 0x10 returns 0 with ack and no err.
REQ-043 Assert wb_rst_n_i low during a pending DBCNT write -> wb_ack_o drops at once; DBCNT reads 0x000186A0 after release.

Source files
------------

// File: rtl/wb_bttns_debounce.sv
// Wishbone slave that synchronizes and debounces push buttons, latches debounced
// rising edges in a W1C register and raises a level interrupt for enabled rises.
module wb_bttns_debounce #(
  parameter int                 NUM_BTTNS = 5,
  parameter int                 CNT_W     = 20,
  parameter logic [CNT_W-1:0]   DB_RESET  = 20'd100000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [1:0]           wb_bte_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  input  logic [NUM_BTTNS-1:0] bttns_i,
  output logic                 irq_o
);

  localparam logic [3:0] OFF_DATA  = 4'h0;
  localparam logic [3:0] OFF_RISE  = 4'h1;
  localparam logic [3:0] OFF_IE    = 4'h2;
  localparam logic [3:0] OFF_DBCNT = 4'h3;

  logic [NUM_BTTNS-1:0] sync1_r, sync2_r, data_r, rise_r, ie_r;
  logic [CNT_W-1:0]     cnt_r     [NUM_BTTNS];
  logic [CNT_W-1:0]     cnt_nxt_s [NUM_BTTNS];
  logic [CNT_W-1:0]     dbcnt_r, thr_s;
  logic [CNT_W:0]       inc_s;
  logic [NUM_BTTNS-1:0] commit_s, rise_set_s;
  logic                 ack_r, irq_r;
  logic [31:0]          dat_r;
  logic                 req_s, wr_s;
  logic [3:0]           adr_s;
  logic [31:0]          byte_mask_s, wr_bits_s, rd_s;
  logic [31:0]          data32_s, rise32_s, ie32_s, dbcnt32_s;
  logic [31:0]          ie_wr_s, dbcnt_wr_s, rise_clr_s;
  logic                 unused_s;

  assign adr_s    = wb_adr_i[5:2];
  assign req_s    = wb_cyc_i & wb_stb_i & ~ack_r;
  assign wr_s     = req_s & wb_we_i;
  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r & {32{wb_cyc_i & wb_stb_i}};
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign irq_o    = irq_r;
  assign unused_s = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:6], wb_adr_i[1:0],
                      ie_wr_s, dbcnt_wr_s, rise_clr_s};

  // Per-button debounce counters; a zero DBCNT behaves like a threshold of one.
  always_comb begin
    thr_s    = (dbcnt_r == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : dbcnt_r;
    inc_s    = {(CNT_W+1){1'b0}};
    commit_s = {NUM_BTTNS{1'b0}};
    for (int i = 0; i < NUM_BTTNS; i++) begin
      inc_s = {1'b0, cnt_r[i]} + {{CNT_W{1'b0}}, 1'b1};
      if (sync2_r[i] == data_r[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (inc_s >= {1'b0, thr_s}) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
        commit_s[i]  = 1'b1;
      end else begin
        cnt_nxt_s[i] = inc_s[CNT_W-1:0];
      end
    end
    rise_set_s = commit_s & sync2_r;
  end

  // Register read mux and byte-lane write merge, all zero-extended to 32 bits.
  always_comb begin
    byte_mask_s = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wr_bits_s   = wb_dat_i & byte_mask_s;
    data32_s    = 32'd0;
    rise32_s    = 32'd0;
    ie32_s      = 32'd0;
    dbcnt32_s   = 32'd0;
    data32_s[NUM_BTTNS-1:0] = data_r;
    rise32_s[NUM_BTTNS-1:0] = rise_r;
    ie32_s[NUM_BTTNS-1:0]   = ie_r;
    dbcnt32_s[CNT_W-1:0]    = dbcnt_r;
    case (adr_s)
      OFF_DATA:  rd_s = data32_s;
      OFF_RISE:  rd_s = rise32_s;
      OFF_IE:    rd_s = ie32_s;
      OFF_DBCNT: rd_s = dbcnt32_s;
      default:   rd_s = 32'd0;
    endcase
    ie_wr_s    = (ie32_s & ~byte_mask_s) | wr_bits_s;
    dbcnt_wr_s = (dbcnt32_s & ~byte_mask_s) | wr_bits_s;
    if (wr_s && (adr_s == OFF_RISE)) begin
      rise_clr_s = wr_bits_s;
    end else begin
      rise_clr_s = 32'd0;
    end
  end

  // Synchronizers, debounce state and counters.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      sync1_r <= {NUM_BTTNS{1'b0}};
      sync2_r <= {NUM_BTTNS{1'b0}};
      data_r  <= {NUM_BTTNS{1'b0}};
      for (int i = 0; i < NUM_BTTNS; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= bttns_i;
      sync2_r <= sync1_r;
      data_r  <= (data_r & ~commit_s) | (sync2_r & commit_s);
      for (int i = 0; i < NUM_BTTNS; i++) cnt_r[i] <= cnt_nxt_s[i];
    end
  end

  // Control registers; a rise event outranks a simultaneous W1C clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rise_r  <= {NUM_BTTNS{1'b0}};
      ie_r    <= {NUM_BTTNS{1'b0}};
      dbcnt_r <= DB_RESET;
      irq_r   <= 1'b0;
    end else begin
      rise_r <= (rise_r & ~rise_clr_s[NUM_BTTNS-1:0]) | rise_set_s;
      irq_r  <= |(rise_r & ie_r);
      if (wr_s && (adr_s == OFF_IE)) begin
        ie_r <= ie_wr_s[NUM_BTTNS-1:0];
      end else begin
        ie_r <= ie_r;
      end
      if (wr_s && (adr_s == OFF_DBCNT)) begin
        dbcnt_r <= dbcnt_wr_s[CNT_W-1:0];
      end else begin
        dbcnt_r <= dbcnt_r;
      end
    end
  end

  // Single-cycle acknowledge with read data captured at the request cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= req_s;
      dat_r <= req_s ? rd_s : 32'd0;
    end
  end

endmodule

// File: tb/tb_wb_bttns_debounce.sv
// Randomized scoreboard bench for wb_bttns_debounce: a run-length button model
// predicts register contents, ack timing and irq; a monitor checks every ack.
module tb_wb_bttns_debounce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty, irq;
  logic [4:0]  bttns;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [4:0]  m_data, m_rise, m_ie;
  logic [19:0] m_dbcnt;
  logic        m_ack, m_irq;
  logic [4:0]  raw_q[$];
  logic [4:0]  sync_q[$];
  logic [32:0] sb_q[$];

  wb_bttns_debounce dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_r), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .bttns_i(bttns), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] ref_read(input logic [3:0] off);
    case (off)
      4'h0:    return {27'd0, m_data};
      4'h1:    return {27'd0, m_rise};
      4'h2:    return {27'd0, m_ie};
      4'h3:    return {12'd0, m_dbcnt};
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: a button commits once its synchronized level has differed
  // from the debounced level for max(DBCNT,1) consecutive cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data = 5'd0; m_rise = 5'd0; m_ie = 5'd0; m_dbcnt = 20'd100000;
      m_ack = 1'b0; m_irq = 1'b0;
      raw_q = {5'd0, 5'd0};
      sync_q.delete();
      sb_q.delete();
    end else begin
      logic        req;
      logic [4:0]  sv, nd, set_v, clr;
      logic [31:0] m;
      int          thr, run;
      req = cyc & stb & ~m_ack;
      if (req) sb_q.push_back({~we, ref_read(adr[5:2])});
      raw_q.push_back(bttns);
      sv = raw_q.pop_front();
      sync_q.push_back(sv);
      if (sync_q.size() > 64) void'(sync_q.pop_front());
      thr = (m_dbcnt == 20'd0) ? 1 : int'(m_dbcnt);
      nd = m_data; set_v = 5'd0; clr = 5'd0;
      for (int i = 0; i < 5; i++) begin
        run = 0;
        for (int j = sync_q.size() - 1; j >= 0; j--) begin
          if (sync_q[j][i] == m_data[i]) break;
          run++;
        end
        if (run >= thr) begin
          nd[i] = sv[i];
          set_v[i] = sv[i];
        end
      end
      m_irq = |(m_rise & m_ie);
      if (req && we) begin
        m = lane_mask(sel);
        case (adr[5:2])
          4'h1: clr = dat_w[4:0] & m[4:0];
          4'h2: m_ie = (m_ie & ~m[4:0]) | (dat_w[4:0] & m[4:0]);
          4'h3: m_dbcnt = (m_dbcnt & ~m[19:0]) | (dat_w[19:0] & m[19:0]);
          default: ;
        endcase
      end
      m_rise = (m_rise & ~clr) | set_v;
      m_data = nd;
      m_ack  = req;
    end
  end

  // Monitor: protocol/irq every cycle, scoreboard pop on each acknowledge.
  always @(negedge clk) begin
    logic [32:0] e;
    chk("ack_timing", {31'd0, ack}, {31'd0, m_ack});
    chk("irq_level", {31'd0, irq}, {31'd0, m_irq});
    chk("err_rty", {30'd0, err, rty}, 32'd0);
    if (ack) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e[32]) chk("read_data", dat_r, e[31:0]);
      end
    end else begin
      chk("dat_idle_zero", dat_r, 32'd0);
    end
  end

  // Called just after a rising edge; returns just after the edge following ack.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    bit got = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    rd = 32'd0;
    for (int n = 0; n < 4 && !got; n++) begin
      @(negedge clk);
      if (ack) begin got = 1; rd = dat_r; end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press_at(input int b, input logic v, input int k, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
    bttns[b] = v;
    idle(k - 1);
    bus(w, a, d, s, rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int nacks;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat_w = 32'd0; sel = 4'd0;
    cti = 3'd0; bte = 2'd0; bttns = 5'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_outputs", {30'd0, ack, irq}, 32'd0);

    // back-to-back reads of DBCNT after reset
    nacks = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hC; sel = 4'hF;
    repeat (8) begin @(negedge clk); if (ack) nacks++; end
    @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;
    chk("b2b_ack_count", nacks, 32'd4);
    bus(1'b0, 32'h10, 32'd0, 4'hF, rd); chk("unmapped_read", rd, 32'd0);
    bus(1'b0, 32'h0, 32'd0, 4'hF, rd);  chk("rst_data", rd, 32'd0);
    bus(1'b0, 32'h4, 32'd0, 4'hF, rd);  chk("rst_rise", rd, 32'd0);
    bus(1'b0, 32'h8, 32'd0, 4'hF, rd);  chk("rst_ie", rd, 32'd0);
    bus(1'b0, 32'hC, 32'd0, 4'hF, rd);  chk("rst_dbcnt", rd, 32'h000186A0);

    // latency: DATA[0] is still 0 when sampled 6 edges after the raw edge, 1 at 7
    bus(1'b1, 32'hC, 32'd4, 4'hF, rd);
    press_at(0, 1'b1, 6, 1'b0, 32'h0, 32'd0, 4'hF, rd); chk("lat_edge6", rd, 32'd0);
    bttns[0] = 1'b0; idle(12);
    press_at(0, 1'b1, 7, 1'b0, 32'h0, 32'd0, 4'hF, rd); chk("lat_edge7", rd, 32'd1);
    bus(1'b0, 32'h4, 32'd0, 4'hF, rd); chk("rise_btn0", rd, 32'd1);
    chk("irq_ie_off", {31'd0, irq}, 32'd0);

    // glitch rejection then a qualifying pulse on button 2
    bttns[2] = 1'b1; idle(3); bttns[2] = 1'b0; idle(10);
    bus(1'b0, 32'h0, 32'd0, 4'hF, rd); chk("glitch_data", rd, 32'd1);
    bus(1'b0, 32'h4, 32'd0, 4'hF, rd); chk("glitch_rise", rd, 32'd1);
    bttns[2] = 1'b1; idle(5); bttns[2] = 1'b0; idle(12);
    bus(1'b0, 32'h4, 32'd0, 4'hF, rd); chk("pulse5_rise", rd, 32'd5);

    // interrupt and byte-lane W1C
    bus(1'b1, 32'h4, 32'h1F, 4'h1, rd);
    bttns = 5'd0; idle(12);
    bus(1'b1, 32'h8, 32'h3, 4'hF, rd);
    bttns = 5'd3; idle(12);
    bus(1'b0, 32'h4, 32'd0, 4'hF, rd); chk("rise_pair", rd, 32'd3);
    chk("irq_set", {31'd0, irq}, 32'd1);
    bus(1'b1, 32'h4, 32'h1, 4'h1, rd);
    bus(1'b0, 32'h4, 32'd0, 4'hF, rd); chk("w1c_bit0", rd, 32'd2);
    chk("irq_still", {31'd0, irq}, 32'd1);
    bus(1'b1, 32'h4, 32'h2, 4'h0, rd);
    bus(1'b0, 32'h4, 32'd0, 4'hF, rd); chk("w1c_sel_off", rd, 32'd2);
    bus(1'b1, 32'h4, 32'h2, 4'h1, rd);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // W1C on the same edge a new rise of button 1 commits
    bttns[1] = 1'b0; idle(12);
    press_at(1, 1'b1, 6, 1'b1, 32'h4, 32'h2, 4'h1, rd);
    bus(1'b0, 32'h4, 32'd0, 4'hF, rd); chk("set_beats_clr", rd, 32'd2);

    // randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      logic [31:0] a;
      if ($urandom_range(0, 2) == 0) bttns = bttns ^ 5'($urandom_range(1, 31));
      idle($urandom_range(0, 5));
      a = 32'($urandom_range(0, 15)) << 2;
      case ($urandom_range(0, 4))
        0, 1: bus(1'b0, a, 32'd0, 4'hF, rd);
        2:    bus(1'b1, 32'h8, 32'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), rd);
        3:    bus(1'b1, 32'h4, 32'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), rd);
        default: bus(1'b1, 32'hC, 32'($urandom_range(0, 6)), 4'($urandom_range(0, 15)), rd);
      endcase
    end

    // reset during a pending DBCNT write, and while ack is high
    bttns = 5'd0; idle(12);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'hC; dat_w = 32'd7; sel = 4'hF;
    #2 rst_n = 1'b0;
    #1 chk("rst_pending_ack", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    idle(2); rst_n = 1'b1;
    bus(1'b0, 32'hC, 32'd0, 4'hF, rd); chk("dbcnt_after_rst", rd, 32'h000186A0);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hC; sel = 4'hF;
    @(posedge clk); #1;
    chk("ack_before_rst", {31'd0, ack}, 32'd1);
    rst_n = 1'b0;
    #1 chk("ack_drops_rst", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    idle(2); rst_n = 1'b1;
    bus(1'b0, 32'hC, 32'd0, 4'hF, rd); chk("dbcnt_final", rd, 32'h000186A0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
